memory_arbiter: RTL and testbench

- Parametrised round-robin RAM arbiter serving CPUS cores, each with one icache channel and one dcache channel, onto a single shared RAM port.
- Sits between the per-core caches and the RAM model, as the next-generation replacement of the single-core memory controller.
- Adds registered fair arbitration, grant locking until transfer completion, request abort handling, and RAM error/timeout reporting.

---
 rtl/memory_arbiter.sv | 130 +++++++++++++
 tb/tb_memory_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter multiplexing per-core icache/dcache channels onto one
// shared RAM port, with grant locking, abort handling and error/timeout reporting.
module memory_arbiter #(
  parameter int CPUS    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*ADDR_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*DATA_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*ADDR_W-1:0] daddr,
  input  logic [CPUS*DATA_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*DATA_W-1:0] dload,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  output logic                   ramREN,
  output logic                   ramWEN,
  input  logic [DATA_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic [2*CPUS-1:0]      err
);
  localparam int N  = 2 * CPUS;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, pick, gnt_inc;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [N-1:0]  req, cwait;
  logic          granted_req;

  genvar gi;
  generate
    for (gi = 0; gi < CPUS; gi++) begin : g_chan
      assign req[2*gi]   = iREN[gi];
      assign req[2*gi+1] = dREN[gi] | dWEN[gi];
      assign iwait[gi]   = cwait[2*gi];
      assign dwait[gi]   = cwait[2*gi+1];
      assign iload[gi*DATA_W +: DATA_W] =
        (state_q == GRANT && gnt_q == GW'(2*gi)) ? ramload : '0;
      assign dload[gi*DATA_W +: DATA_W] =
        (state_q == GRANT && gnt_q == GW'(2*gi+1)) ? ramload : '0;
    end
  endgenerate

  // Descending scan so the channel closest to ptr (offset 0) wins last.
  always_comb begin
    pick = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[GW'((int'(ptr_q) + i) % N)]) pick = GW'((int'(ptr_q) + i) % N);
    end
  end

  assign gnt_inc     = (gnt_q == GW'(N - 1)) ? '0 : gnt_q + 1'b1;
  assign granted_req = req[gnt_q];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    tcnt_d   = tcnt_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    cwait    = '1;
    err      = '0;
    if (state_q == IDLE) begin
      if (|req) begin
        gnt_d   = pick;
        tcnt_d  = '0;
        state_d = GRANT;
      end
    end else begin
      // RAM port follows the granted channel's live request lines.
      for (int k = 0; k < CPUS; k++) begin
        if (gnt_q == GW'(2*k)) begin
          ramREN  = iREN[k];
          ramaddr = iaddr[k*ADDR_W +: ADDR_W];
        end else if (gnt_q == GW'(2*k+1)) begin
          ramaddr = daddr[k*ADDR_W +: ADDR_W];
          if (dWEN[k]) begin
            ramWEN   = 1'b1;
            ramstore = dstore[k*DATA_W +: DATA_W];
          end else begin
            ramREN = dREN[k];
          end
        end
      end
      if (!granted_req) begin
        state_d = IDLE;
      end else if (ramstate == RAM_ACCESS) begin
        cwait[gnt_q] = 1'b0;
        ptr_d        = gnt_inc;
        state_d      = IDLE;
      end else if (ramstate == RAM_ERROR || tcnt_q == TW'(TIMEOUT - 1)) begin
        err[gnt_q] = 1'b1;
        ptr_d      = gnt_inc;
        state_d    = IDLE;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized scoreboard bench for memory_arbiter: a RAM responder, a
// round-robin reference model and a monitor checking every completion/error.
module tb_memory_arbiter;
  localparam int CPUS = 2;
  localparam int N    = 2 * CPUS;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 64;

  logic                CLK, RST;
  logic [CPUS-1:0]     iREN, iwait, dREN, dWEN, dwait;
  logic [CPUS*AW-1:0]  iaddr, daddr;
  logic [CPUS*DW-1:0]  iload, dload, dstore;
  logic [AW-1:0]       ramaddr;
  logic [DW-1:0]       ramstore, ramload;
  logic                ramREN, ramWEN;
  logic [1:0]          ramstate;
  logic [N-1:0]        err;

  memory_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait),
    .dload(dload), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  typedef struct {
    int          chan;
    bit          is_err;
    int          cyc;
    logic [31:0] addr;
    bit          we;
    logic [31:0] store;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          d;
    bit          is_err;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int compared   = 0;
  int mismatched = 0;
  int ptr_m      = 0;

  logic [31:0] ch_addr[N];
  logic [31:0] ch_store[N];
  bit          ch_we[N];
  bit          ch_re[N];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] m);
    for (int k = 0; k < CPUS; k++) begin
      iREN[k]              = m[2*k];
      iaddr[k*AW +: AW]    = ch_addr[2*k];
      dWEN[k]              = m[2*k+1] & ch_we[2*k+1];
      dREN[k]              = m[2*k+1] & (ch_re[2*k+1] | ~ch_we[2*k+1]);
      daddr[k*AW +: AW]    = ch_addr[2*k+1];
      dstore[k*DW +: DW]   = ch_store[2*k+1];
    end
  endtask

  task automatic randomize_channels();
    for (int c = 0; c < N; c++) begin
      ch_addr[c]  = $urandom;
      ch_store[c] = $urandom;
      ch_we[c]    = (c % 2 == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
      ch_re[c]    = bit'($urandom_range(0, 1));
    end
  endtask

  // Reference: every requester holds until served, so service order is the
  // requesting channels sorted by distance from the round-robin pointer.
  task automatic run_phase(input logic [N-1:0] mask);
    logic [N-1:0] active, served, wl;
    int last, budget, r;
    exp_t  e;
    plan_t p;
    randomize_channels();
    last = ptr_m;
    for (int off = 0; off < N; off++) begin
      int c;
      c = (ptr_m + off) % N;
      if (mask[c]) begin
        r       = $urandom_range(0, 19);
        p.d     = $urandom_range(1, 5);
        p.rdata = $urandom;
        p.is_err = (r >= 14);
        if (r >= 18) p.d = TO + 5;
        e.chan   = c;
        e.is_err = p.is_err || (p.d > TO);
        e.cyc    = (p.d > TO) ? TO : p.d;
        e.addr   = ch_addr[c];
        e.we     = ch_we[c];
        e.store  = ch_store[c];
        e.rdata  = p.rdata;
        plan_q.push_back(p);
        exp_q.push_back(e);
        last = c;
      end
    end
    ptr_m = (last + 1) % N;
    @(posedge CLK); #1;
    active = mask;
    drive(active);
    budget = 0;
    while (active != 0 && budget < 3000) begin
      @(negedge CLK);
      for (int k = 0; k < CPUS; k++) begin
        wl[2*k]   = ~iwait[k];
        wl[2*k+1] = ~dwait[k];
      end
      served = wl | err;
      @(posedge CLK); #1;
      active = active & ~served;
      drive(active);
      budget++;
    end
    check("phase_drained", 64'(active), 64'd0);
    repeat (2) @(posedge CLK);
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(ramREN || ramWEN) && n < 20);
    check(name, 64'(ramREN | ramWEN), 64'd1);
  endtask

  // RAM responder: answers each grant with the next planned outcome.
  initial begin
    bit    in_grant, have;
    int    rcyc;
    plan_t cur;
    in_grant = 0; have = 0; rcyc = 0;
    ramstate = 2'd0;
    ramload  = '0;
    forever begin
      @(posedge CLK); #1;
      if (RST || !(ramREN || ramWEN)) begin
        in_grant = 0;
        ramstate = 2'd0;
      end else begin
        if (!in_grant) begin
          in_grant = 1;
          rcyc     = 1;
          have     = (plan_q.size() > 0);
          if (have) cur = plan_q.pop_front();
        end else begin
          rcyc++;
        end
        ramload = have ? cur.rdata : $urandom;
        if (have && rcyc == cur.d) ramstate = cur.is_err ? 2'd3 : 2'd2;
        else ramstate = 2'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the scoreboard whenever a wait goes low or an err pulses.
  initial begin
    int          gcyc, ch, bad_other;
    logic [N-1:0] wl, any;
    logic [31:0] ld;
    exp_t        e;
    gcyc = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        gcyc = 0;
      end else begin
        gcyc = (ramREN || ramWEN) ? gcyc + 1 : 0;
        for (int k = 0; k < CPUS; k++) begin
          wl[2*k]   = ~iwait[k];
          wl[2*k+1] = ~dwait[k];
        end
        any = wl | err;
        check("single_response", 64'(($countones(wl) > 1) || ($countones(err) > 1) ||
              (wl != 0 && err != 0)), 64'd0);
        if (any != 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_response", 64'({wl, err}), 64'd0);
          end else begin
            e  = exp_q.pop_front();
            ch = 0;
            for (int c = 0; c < N; c++) if (any[c]) ch = c;
            $display("txn chan=%0d err=%0d cyc=%0d addr=%08h we=%0d", ch, err != 0, gcyc, ramaddr, ramWEN);
            check("chan", 64'(ch), 64'(e.chan));
            check("is_err", 64'(err != 0), 64'(e.is_err));
            check("grant_cycle", 64'(gcyc), 64'(e.cyc));
            check("ramaddr", 64'(ramaddr), 64'(e.addr));
            check("ramWEN", 64'(ramWEN), 64'(e.we));
            check("ramREN", 64'(ramREN), 64'(!e.we));
            if (e.we) check("ramstore", 64'(ramstore), 64'(e.store));
            bad_other = 0;
            for (int c = 0; c < N; c++) begin
              ld = (c % 2 == 0) ? iload[(c/2)*DW +: DW] : dload[(c/2)*DW +: DW];
              if (c == e.chan) check("load", 64'(ld), 64'(e.rdata));
              else if (ld != 0) bad_other++;
            end
            check("other_loads_zero", 64'(bad_other), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    int c;
    RST = 1'b1;
    for (int i = 0; i < N; i++) begin
      ch_addr[i] = '0; ch_store[i] = '0; ch_we[i] = 0; ch_re[i] = 0;
    end
    drive('0);
    iREN = '1;
    repeat (2) @(negedge CLK);
    check("rst_iwait", 64'(iwait), 64'({CPUS{1'b1}}));
    check("rst_dwait", 64'(dwait), 64'({CPUS{1'b1}}));
    check("rst_ramREN", 64'(ramREN), 64'd0);
    check("rst_ramWEN", 64'(ramWEN), 64'd0);
    check("rst_ramaddr", 64'(ramaddr), 64'd0);
    check("rst_ramstore", 64'(ramstore), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_iload", 64'(iload), 64'd0);
    check("rst_dload", 64'(dload), 64'd0);
    drive('0);
    @(negedge CLK);
    RST = 1'b0;

    run_phase('1);
    for (int ph = 0; ph < 30; ph++) run_phase(N'($urandom_range(1, (1 << N) - 1)));

    // Abort: a lone requester drops mid-grant; the pointer must not move.
    randomize_channels();
    c = (ptr_m + 2) % N;
    @(posedge CLK); #1;
    drive(N'(1 << c));
    wait_grant("abort_grant_seen");
    @(posedge CLK); #1;
    drive('0);
    #1;
    check("abort_ram_released", 64'(ramREN | ramWEN), 64'd0);
    repeat (4) @(posedge CLK);
    run_phase('1);

    // Asynchronous reset between edges during a grant.
    randomize_channels();
    @(posedge CLK); #1;
    drive('1);
    wait_grant("async_grant_seen");
    #2;
    RST = 1'b1;
    #1;
    check("async_ram_en", 64'(ramREN | ramWEN), 64'd0);
    check("async_waits", 64'({iwait, dwait}), 64'({2*CPUS{1'b1}}));
    check("async_err", 64'(err), 64'd0);
    drive('0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    ptr_m = 0;
    run_phase('1);
    run_phase('1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
